clk_freq_monitor: RTL and testbench

Multi-channel clock frequency and lock monitor, running entirely in the clk_ref domain. Each of NCLK monitored clocks supplies a free-running Gray-coded edge counter generated in its own domain. The block measures edges per programmable gate window and tracks min/max rate. It flags out-of-range rates against per-channel thresholds and counts PLL/MMCM unlock events. Outputs feed the IPIF register decoder of the enclosing AXI wrapper.

---
 rtl/clk_freq_monitor.sv | 167 ++++++++++++++++
 tb/tb_clk_freq_monitor.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_freq_monitor.sv
// rtl/clk_freq_monitor.sv - multi-channel clock rate / lock monitor, all logic in clk_ref domain
// Optional: CLK_FREQ_MONITOR_LOCK_GATE_EN discards windows in which a channel lost lock.
module clk_freq_monitor #(
   parameter int NCLK        = 4,
   parameter int CNT_W       = 16,
   parameter int RATE_W      = 32,
   parameter int GATE_W      = 32,
   parameter int UNLOCK_W    = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk_ref,
   input  logic                     aresetn,
   input  logic                     enable,
   input  logic [GATE_W-1:0]        gate_cycles,
   input  logic [NCLK*CNT_W-1:0]    test_cnt_gray,
   input  logic [NCLK-1:0]          locked,
   input  logic [NCLK*RATE_W-1:0]   thr_lo,
   input  logic [NCLK*RATE_W-1:0]   thr_hi,
   input  logic [NCLK-1:0]          clear,
   output logic [NCLK*RATE_W-1:0]   rate,
   output logic [NCLK*RATE_W-1:0]   rate_min,
   output logic [NCLK*RATE_W-1:0]   rate_max,
   output logic [NCLK-1:0]          rate_valid,
   output logic [NCLK-1:0]          alarm,
   output logic [NCLK-1:0]          alarm_sticky,
   output logic [NCLK*UNLOCK_W-1:0] unlocks,
   output logic [NCLK-1:0]          locked_sync
);

   typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;

   function automatic logic [CNT_W-1:0] gray2bin(input logic [CNT_W-1:0] g);
      logic [CNT_W-1:0] b;
      b[CNT_W-1] = g[CNT_W-1];
      for (int k = CNT_W-2; k >= 0; k--) b[k] = b[k+1] ^ g[k];
      return b;
   endfunction

   logic [SYNC_STAGES-1:0][NCLK*CNT_W-1:0] gray_sync;
   logic [SYNC_STAGES-1:0][NCLK-1:0]       lock_sync;
   logic [NCLK-1:0][CNT_W-1:0]             prev_bin, cur_bin, delta;
   logic [NCLK-1:0][RATE_W-1:0]            acc, acc_next, rate_q, min_q, max_q;
   logic [NCLK-1:0][UNLOCK_W-1:0]          unl_q;
   logic [NCLK-1:0]                        new_alarm, keep, upd, valid_q, alarm_q, sticky_q, fall;
   logic [GATE_W-1:0]                      gate_cnt, gate_q;
   logic [RATE_W:0]                        sum;
   state_t                                 state, state_nxt;
   logic                                   go, abort, tick, tick_run;

   assign go       = enable && (gate_cycles >= GATE_W'(2));
   assign abort    = !go || (gate_cycles != gate_q);
   assign tick     = (gate_cnt == gate_cycles - GATE_W'(1));
   assign tick_run = (state == RUN) && tick && !abort;
   assign upd      = keep & {NCLK{tick_run}};

   always_comb begin
      sum = '0;
      for (int i = 0; i < NCLK; i++) begin
         cur_bin[i]   = gray2bin(gray_sync[SYNC_STAGES-1][i*CNT_W +: CNT_W]);
         delta[i]     = cur_bin[i] - prev_bin[i];
         sum          = {1'b0, acc[i]} + (RATE_W+1)'(delta[i]);
         acc_next[i]  = sum[RATE_W] ? '1 : sum[RATE_W-1:0];
         new_alarm[i] = (acc_next[i] < thr_lo[i*RATE_W +: RATE_W]) ||
                        (acc_next[i] > thr_hi[i*RATE_W +: RATE_W]);
         fall[i]      = lock_sync[SYNC_STAGES-1][i] & ~lock_sync[SYNC_STAGES-2][i];
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (go) state_nxt = PRIME;
         PRIME:   if (abort) state_nxt = IDLE; else if (tick) state_nxt = RUN;
         RUN:     if (abort) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_ref or negedge aresetn) begin
      if (!aresetn) begin
         state     <= IDLE;
         gate_cnt  <= '0;
         gate_q    <= '0;
         gray_sync <= '0;
         lock_sync <= '0;
         prev_bin  <= '0;
         acc       <= '0;
      end else begin
         state     <= state_nxt;
         gate_q    <= gate_cycles;
         gray_sync <= {gray_sync[SYNC_STAGES-2:0], test_cnt_gray};
         lock_sync <= {lock_sync[SYNC_STAGES-2:0], locked};
         prev_bin  <= cur_bin;
         // A window boundary folds the boundary cycle's delta into the result, so no edge is lost
         if (state == IDLE || abort || tick) begin
            gate_cnt <= '0;
            acc      <= '0;
         end else begin
            gate_cnt <= gate_cnt + GATE_W'(1);
            acc      <= acc_next;
         end
      end
   end

`ifdef CLK_FREQ_MONITOR_LOCK_GATE_EN
   logic [NCLK-1:0] lost, reprime;
   assign keep = ~(lost | ~lock_sync[SYNC_STAGES-1] | reprime);

   always_ff @(posedge clk_ref or negedge aresetn) begin
      if (!aresetn) begin
         lost    <= '0;
         reprime <= '0;
      end else if (state != RUN || abort) begin
         lost    <= '0;
         reprime <= '0;
      end else if (tick) begin
         reprime <= lost | ~lock_sync[SYNC_STAGES-1];
         lost    <= '0;
      end else begin
         lost    <= lost | ~lock_sync[SYNC_STAGES-1];
      end
   end
`else
   assign keep = '1;
`endif

   always_ff @(posedge clk_ref or negedge aresetn) begin
      if (!aresetn) begin
         valid_q  <= '0;
         rate_q   <= '0;
         min_q    <= '1;
         max_q    <= '0;
         alarm_q  <= '0;
         sticky_q <= '0;
         unl_q    <= '0;
      end else begin
         valid_q <= upd;
         for (int i = 0; i < NCLK; i++) begin
            if (upd[i]) begin
               rate_q[i]  <= acc_next[i];
               alarm_q[i] <= new_alarm[i];
            end
            if (clear[i] && upd[i])                     min_q[i] <= acc_next[i];
            else if (clear[i])                          min_q[i] <= '1;
            else if (upd[i] && acc_next[i] < min_q[i])  min_q[i] <= acc_next[i];
            if (clear[i] && upd[i])                     max_q[i] <= acc_next[i];
            else if (clear[i])                          max_q[i] <= '0;
            else if (upd[i] && acc_next[i] > max_q[i])  max_q[i] <= acc_next[i];
            if (upd[i] && new_alarm[i])                 sticky_q[i] <= 1'b1;
            else if (clear[i])                          sticky_q[i] <= 1'b0;
            if (fall[i] && clear[i])                    unl_q[i] <= UNLOCK_W'(1);
            else if (clear[i])                          unl_q[i] <= '0;
            else if (fall[i] && unl_q[i] != '1)         unl_q[i] <= unl_q[i] + UNLOCK_W'(1);
         end
      end
   end

   assign rate         = rate_q;
   assign rate_min     = min_q;
   assign rate_max     = max_q;
   assign rate_valid   = valid_q;
   assign alarm        = alarm_q;
   assign alarm_sticky = sticky_q;
   assign unlocks      = unl_q;
   assign locked_sync  = lock_sync[SYNC_STAGES-1];

endmodule

// File: tb/tb_clk_freq_monitor.sv
// tb/tb_clk_freq_monitor.sv - table-driven and randomized bench for clk_freq_monitor
module tb_clk_freq_monitor;
   localparam int NCLK = 4, CNT_W = 16, RATE_W = 32, GATE_W = 32, UNLOCK_W = 32, SYNC_STAGES = 2;
`ifdef CLK_FREQ_MONITOR_LOCK_GATE_EN
   localparam bit LG = 1'b1;
`else
   localparam bit LG = 1'b0;
`endif

   logic                     clk_ref = 1'b0;
   logic                     aresetn, enable;
   logic [GATE_W-1:0]        gate_cycles;
   logic [NCLK*CNT_W-1:0]    test_cnt_gray;
   logic [NCLK-1:0]          locked, clear;
   logic [NCLK*RATE_W-1:0]   thr_lo, thr_hi;
   logic [NCLK*RATE_W-1:0]   rate, rate_min, rate_max;
   logic [NCLK-1:0]          rate_valid, alarm, alarm_sticky, locked_sync;
   logic [NCLK*UNLOCK_W-1:0] unlocks;

   clk_freq_monitor #(.NCLK(NCLK), .CNT_W(CNT_W), .RATE_W(RATE_W), .GATE_W(GATE_W),
                      .UNLOCK_W(UNLOCK_W), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk_ref(clk_ref), .aresetn(aresetn), .enable(enable), .gate_cycles(gate_cycles),
      .test_cnt_gray(test_cnt_gray), .locked(locked), .thr_lo(thr_lo), .thr_hi(thr_hi),
      .clear(clear), .rate(rate), .rate_min(rate_min), .rate_max(rate_max),
      .rate_valid(rate_valid), .alarm(alarm), .alarm_sticky(alarm_sticky),
      .unlocks(unlocks), .locked_sync(locked_sync));

   always #5 clk_ref = ~clk_ref;

   // Each test clock advances by alternating steps a,b per clk_ref cycle: average (a+b)/2 edges/cycle
   logic [CNT_W-1:0] cnt [NCLK];
   int unsigned      step_a [NCLK], step_b [NCLK];
   bit               ph = 1'b0;
   always @(negedge clk_ref) begin
      for (int i = 0; i < NCLK; i++) begin
         cnt[i] = cnt[i] + CNT_W'(ph ? step_b[i] : step_a[i]);
         test_cnt_gray[i*CNT_W +: CNT_W] = cnt[i] ^ (cnt[i] >> 1);
      end
      ph = !ph;
   end

   typedef struct {
      int unsigned gate;
      int unsigned a [NCLK];
      int unsigned b [NCLK];
      int unsigned lo [NCLK];
      int unsigned hi [NCLK];
      int unsigned e_rate [NCLK];
      bit          e_alarm [NCLK];
   } vec_t;

   vec_t        vt [6];
   int          tests = 0, failed = 0;
   logic [31:0] mdl_min [NCLK], mdl_max [NCLK];
   bit          mdl_sticky [NCLK];

   function automatic int unsigned model_rate(int unsigned g, int unsigned a, int unsigned b);
      return (g / 2) * (a + b);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_valid(input int budget, output int n);
      n = 0;
      do begin
         @(posedge clk_ref); #1;
         n++;
      end while (rate_valid == '0 && n < budget);
      if (rate_valid == '0) begin
         tests++; failed++;
         $display("FAIL wait_valid: no rate_valid within %0d cycles", budget);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      @(negedge clk_ref);
      enable = 1'b0;
      gate_cycles = v.gate;
      for (int i = 0; i < NCLK; i++) begin
         step_a[i] = v.a[i];
         step_b[i] = v.b[i];
         thr_lo[i*RATE_W +: RATE_W] = v.lo[i];
         thr_hi[i*RATE_W +: RATE_W] = v.hi[i];
      end
      @(negedge clk_ref);
      enable = 1'b1;
      wait_valid(2*v.gate + 20, n);
      chk("first_valid_latency", n, 2*v.gate + 1);
      for (int w = 0; w < 2; w++) begin
         if (w == 1) begin
            repeat (v.gate) @(posedge clk_ref);
            #1;
         end
         chk("rate_valid_all", rate_valid, 4'hF);
         for (int i = 0; i < NCLK; i++) begin
            if (v.e_rate[i] < mdl_min[i]) mdl_min[i] = v.e_rate[i];
            if (v.e_rate[i] > mdl_max[i]) mdl_max[i] = v.e_rate[i];
            if (v.e_alarm[i]) mdl_sticky[i] = 1'b1;
            chk($sformatf("rate[%0d]", i), rate[i*RATE_W +: RATE_W], v.e_rate[i]);
            chk($sformatf("alarm[%0d]", i), alarm[i], v.e_alarm[i]);
            chk($sformatf("sticky[%0d]", i), alarm_sticky[i], mdl_sticky[i]);
            chk($sformatf("min[%0d]", i), rate_min[i*RATE_W +: RATE_W], mdl_min[i]);
            chk($sformatf("max[%0d]", i), rate_max[i*RATE_W +: RATE_W], mdl_max[i]);
         end
      end
      @(posedge clk_ref); #1;
      chk("rate_valid_width", rate_valid, 4'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int unsigned r;
      vec_t hv;
      for (int k = 0; k < 6; k++) begin
         vt[k].gate = (k == 0) ? 1000 : 2 * $urandom_range(10, 150);
         for (int i = 0; i < NCLK; i++) begin
            vt[k].a[i] = (k == 0 && i == 0) ? 2 : $urandom_range(0, 40);
            vt[k].b[i] = (k == 0 && i == 0) ? 3 : $urandom_range(0, 40);
            r = model_rate(vt[k].gate, vt[k].a[i], vt[k].b[i]);
            if (k == 0 && i == 0) begin
               vt[k].lo[i] = 2400; vt[k].hi[i] = 2450;
            end else if (k == 3) begin
               vt[k].lo[i] = r + 3; vt[k].hi[i] = r;
            end else if ((i + k) % 2 == 0) begin
               vt[k].lo[i] = r - ((r < 5) ? r : $urandom_range(0, 5));
               vt[k].hi[i] = r + $urandom_range(0, 5);
            end else begin
               vt[k].lo[i] = $urandom_range(0, 12000);
               vt[k].hi[i] = vt[k].lo[i] + $urandom_range(0, 3000);
            end
            vt[k].e_rate[i]  = r;
            vt[k].e_alarm[i] = (r < vt[k].lo[i]) || (r > vt[k].hi[i]);
            mdl_min[i] = '1; mdl_max[i] = '0; mdl_sticky[i] = 1'b0;
            step_a[i] = 0; step_b[i] = 0;
            cnt[i] = (i == 0) ? 16'hF000 : CNT_W'($urandom);
         end
      end

      aresetn = 1'b0; enable = 1'b0; gate_cycles = 1000; locked = '1; clear = '0;
      thr_lo = '0; thr_hi = '0;
      repeat (3) @(posedge clk_ref);
      #1;
      chk("reset_rate", rate, '0);
      chk("reset_min", rate_min[63:0], {64{1'b1}});
      chk("reset_max", rate_max, '0);
      chk("reset_valid", rate_valid, '0);
      chk("reset_sticky", alarm_sticky, '0);
      chk("reset_unlocks", unlocks[63:0], '0);
      @(negedge clk_ref);
      aresetn = 1'b1;

      for (int k = 0; k < 6; k++) run_vec(vt[k]);

      // live alarm follows thresholds; sticky holds until cleared
      run_vec(vt[0]);
      @(negedge clk_ref);
      thr_hi[31:0] = 3000;
      wait_valid(1010, n);
      chk("alarm_off", alarm[0], 1'b0);
      chk("sticky_held", alarm_sticky[0], 1'b1);
      chk("rate_2500", rate[31:0], 2500);
      @(negedge clk_ref); clear = 4'b0001;
      @(negedge clk_ref); clear = 4'b0000;
      chk("sticky_cleared", alarm_sticky[0], 1'b0);
      chk("min_cleared", rate_min[31:0], 32'hFFFF_FFFF);
      chk("max_cleared", rate_max[31:0], 0);
      wait_valid(1010, n);
      chk("min_after_clear", rate_min[31:0], 2500);
      chk("max_after_clear", rate_max[31:0], 2500);

      // clear on the update edge of ch1: min and max both take the new rate
      repeat (999) @(posedge clk_ref);
      @(negedge clk_ref); clear = 4'b0010;
      @(posedge clk_ref); #1;
      chk("coinc_valid", rate_valid[1], 1'b1);
      chk("coinc_min", rate_min[63:32], vt[0].e_rate[1]);
      chk("coinc_max", rate_max[63:32], vt[0].e_rate[1]);
      @(negedge clk_ref); clear = 4'b0000;

      // gate change mid-window: disrupted window dropped, one PRIME, then new rate
      repeat (300) @(posedge clk_ref);
      @(negedge clk_ref); gate_cycles = 500;
      wait_valid(1100, n);
      chk("gate_change_latency", n, 1002);
      chk("rate_1250", rate[31:0], 1250);
      @(posedge clk_ref); #1;
      chk("gate_change_width", rate_valid, 4'h0);

      // reset mid-window
      repeat (200) @(posedge clk_ref);
      @(negedge clk_ref); aresetn = 1'b0;
      #1;
      chk("midreset_rate", rate[31:0], 0);
      chk("midreset_min", rate_min[31:0], 32'hFFFF_FFFF);
      chk("midreset_sticky", alarm_sticky[0], 1'b0);
      @(negedge clk_ref); aresetn = 1'b1;
      wait_valid(1100, n);
      chk("postreset_latency", n, 1001);
      chk("postreset_rate", rate[31:0], 1250);
      chk("postreset_min", rate_min[31:0], 1250);

      // unlock counting on ch2, then a clear landing on a falling edge
      for (int t = 0; t < 3; t++) begin
         @(negedge clk_ref); locked[2] = 1'b0;
         repeat (5) @(negedge clk_ref);
         locked[2] = 1'b1;
         repeat (5) @(negedge clk_ref);
      end
      chk("unlocks_3", unlocks[95:64], 3);
      chk("locked_sync_hi", locked_sync[2], 1'b1);
      locked[2] = 1'b0;
      repeat (SYNC_STAGES-1) @(posedge clk_ref);
      @(negedge clk_ref); clear = 4'b0100;
      @(posedge clk_ref); #1;
      chk("unlocks_clear_fall", unlocks[95:64], 1);
      chk("locked_sync_lo", locked_sync[2], 1'b0);
      @(negedge clk_ref); clear = 4'b0000; locked[2] = 1'b1;

      // ch0 loses lock for 10 cycles mid-window
      wait_valid(1100, n);
      repeat (200) @(posedge clk_ref);
      @(negedge clk_ref); locked[0] = 1'b0;
      repeat (10) @(negedge clk_ref);
      locked[0] = 1'b1;
      repeat (500 - 210) @(posedge clk_ref);
      for (int w = 0; w < 3; w++) begin
         if (w > 0) repeat (500) @(posedge clk_ref);
         #1;
         chk($sformatf("lockgate_valid0_w%0d", w), rate_valid[0], (w == 2) ? 1'b1 : !LG);
         chk($sformatf("lockgate_valid1_w%0d", w), rate_valid[1], 1'b1);
      end
      chk("lockgate_rate", rate[31:0], 1250);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
